// File: rtl/alu_uart_sequencer_pkg.sv
// Shared types and constants for the ALU UART sequencer: frame states,
// state_id phase codes and the highest legal command byte.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP1_LO,
        ST_OP1_HI,
        ST_OP2_LO,
        ST_OP2_HI,
        ST_CMD,
        ST_EXEC,
        ST_WAIT_TX
    } seq_state_e;

    localparam logic [1:0] SID_IDLE = 2'b00;
    localparam logic [1:0] SID_OP1  = 2'b01;
    localparam logic [1:0] SID_OP2  = 2'b10;
    localparam logic [1:0] SID_CMD  = 2'b11;

    localparam logic [1:0] CMD_MAX = 2'd3;

    function automatic logic [1:0] state_to_id(seq_state_e s);
        case (s)
            ST_IDLE:              return SID_IDLE;
            ST_OP1_LO, ST_OP1_HI: return SID_OP1;
            ST_OP2_LO, ST_OP2_HI: return SID_OP2;
            default:              return SID_CMD;
        endcase
    endfunction

    function automatic logic cmd_is_valid(logic [7:0] b);
        return b <= {6'd0, CMD_MAX};
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// Bundle of the sequencer's UART-side inputs and ALU/transmitter-side outputs.
// master = byte source / observer, slave = the sequencer.
interface alu_uart_sequencer_if #(
    parameter int N_BITS = 16
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_busy;
    logic [N_BITS-1:0] op1;
    logic [N_BITS-1:0] op2;
    logic [1:0]        alu_ctrl;
    logic [1:0]        state_id;
    logic              result_valid;
    logic              cmd_err;
    logic              overrun;
    logic              timeout_err;

    modport master (
        output rx_data, rx_ready, tx_busy,
        input  op1, op2, alu_ctrl, state_id, result_valid, cmd_err, overrun, timeout_err
    );

    modport slave (
        input  rx_data, rx_ready, tx_busy,
        output op1, op2, alu_ctrl, state_id, result_valid, cmd_err, overrun, timeout_err
    );
endinterface

// File: rtl/alu_uart_sequencer_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// pulses expire when the count reaches TIMEOUT_CYCLES-1.
module seq_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + CW'(1);
        end
    end

    // A byte arriving on the final cycle wins over the expiry.
    assign expire = enable && !clear && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/alu_uart_sequencer.sv
// Assembles OP1, OP2 and CMD from a byte stream and triggers the result transmitter.
// Define SEQ_TIMEOUT_EN to build in the mid-frame inter-byte timeout.
module alu_uart_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N_BITS         = 16,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              tx_busy,
    output logic [N_BITS-1:0] op1,
    output logic [N_BITS-1:0] op2,
    output logic [1:0]        alu_ctrl,
    output logic [1:0]        state_id,
    output logic              result_valid,
    output logic              cmd_err,
    output logic              overrun,
    output logic              timeout_err
);
    seq_state_e        state_q, state_d;
    logic [7:0]        shadow_q, shadow_d;
    logic [N_BITS-1:0] op1_q, op1_d;
    logic [N_BITS-1:0] op2_q, op2_d;
    logic [1:0]        alu_ctrl_q, alu_ctrl_d;
    logic [1:0]        state_id_q;
    logic              result_valid_q, result_valid_d;
    logic              cmd_err_q, cmd_err_d;
    logic              overrun_q, overrun_d;

`ifdef SEQ_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;
    logic timer_expire;
    logic mid_frame;

    assign mid_frame = (state_q == ST_OP1_HI) || (state_q == ST_OP2_LO) ||
                       (state_q == ST_OP2_HI) || (state_q == ST_CMD);

    seq_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_ready),
        .enable (mid_frame),
        .expire (timer_expire)
    );

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        alu_ctrl_d     = alu_ctrl_q;
        result_valid_d = 1'b0;
        cmd_err_d      = 1'b0;
        overrun_d      = 1'b0;

        case (state_q)
            // IDLE doubles as the OP1 low-byte wait; the first byte of a frame lands here.
            ST_IDLE, ST_OP1_LO: begin
                if (rx_ready) begin
                    shadow_d = rx_data;
                    state_d  = ST_OP1_HI;
                end
            end
            ST_OP1_HI: begin
                if (rx_ready) begin
                    op1_d   = N_BITS'({rx_data, shadow_q});
                    state_d = ST_OP2_LO;
                end
            end
            ST_OP2_LO: begin
                if (rx_ready) begin
                    shadow_d = rx_data;
                    state_d  = ST_OP2_HI;
                end
            end
            ST_OP2_HI: begin
                if (rx_ready) begin
                    op2_d   = N_BITS'({rx_data, shadow_q});
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_ready) begin
                    if (cmd_is_valid(rx_data)) begin
                        alu_ctrl_d = rx_data[1:0];
                        state_d    = ST_EXEC;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            // Bytes arriving while a result is pending are dropped and flagged.
            ST_EXEC, ST_WAIT_TX: begin
                overrun_d = rx_ready;
                if (!tx_busy) begin
                    result_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef SEQ_TIMEOUT_EN
        timeout_err_d = 1'b0;
        if (timer_expire) begin
            timeout_err_d = 1'b1;
            state_d       = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            shadow_q       <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            alu_ctrl_q     <= '0;
            state_id_q     <= SID_IDLE;
            result_valid_q <= 1'b0;
            cmd_err_q      <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            alu_ctrl_q     <= alu_ctrl_d;
            state_id_q     <= state_to_id(state_d);
            result_valid_q <= result_valid_d;
            cmd_err_q      <= cmd_err_d;
            overrun_q      <= overrun_d;
`ifdef SEQ_TIMEOUT_EN
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign op1          = op1_q;
    assign op2          = op2_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign state_id     = state_id_q;
    assign result_valid = result_valid_q;
    assign cmd_err      = cmd_err_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer: frames are issued from a stimulus
// process, expected pulses are queued, and a monitor pops them as they appear.
module tb_alu_uart_sequencer;

    localparam int TB_N_BITS  = 16;
    localparam int TB_TIMEOUT = 100;

    localparam int EV_RESULT  = 0;
    localparam int EV_CMDERR  = 1;
    localparam int EV_OVERRUN = 2;
    localparam int EV_TIMEOUT = 3;

    typedef struct {
        int          kind;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [1:0]  ctrl;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_uart_sequencer_if #(.N_BITS(TB_N_BITS)) bus ();

    alu_uart_sequencer #(
        .N_BITS         (TB_N_BITS),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (bus.rx_data),
        .rx_ready     (bus.rx_ready),
        .tx_busy      (bus.tx_busy),
        .op1          (bus.op1),
        .op2          (bus.op2),
        .alu_ctrl     (bus.alu_ctrl),
        .state_id     (bus.state_id),
        .result_valid (bus.result_valid),
        .cmd_err      (bus.cmd_err),
        .overrun      (bus.overrun),
        .timeout_err  (bus.timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t         exp_q[$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_results = 0;
    int          last_cyc[4] = '{-1000, -1000, -1000, -1000};

    // Reference model: what op1/op2/alu_ctrl should hold after each frame.
    logic [15:0] m_op1  = 16'h0;
    logic [15:0] m_op2  = 16'h0;
    logic [1:0]  m_ctrl = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.op1  = m_op1;
        e.op2  = m_op2;
        e.ctrl = m_ctrl;
        return e;
    endfunction

    task automatic observe(input int kind);
        ev_t e;
        last_cyc[kind] = cyc;
        if (kind == EV_RESULT) n_results++;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        $display("event kind=%0d cyc=%0d op1=%h op2=%h ctrl=%0d", kind, cyc, bus.op1, bus.op2, bus.alu_ctrl);
        check("event_kind", kind, e.kind);
        if (kind == EV_RESULT || kind == EV_CMDERR) begin
            check("event_op1", bus.op1, e.op1);
            check("event_op2", bus.op2, e.op2);
            check("event_ctrl", bus.alu_ctrl, e.ctrl);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.result_valid) observe(EV_RESULT);
            if (bus.cmd_err)      observe(EV_CMDERR);
            if (bus.overrun)      observe(EV_OVERRUN);
            if (bus.timeout_err)  observe(EV_TIMEOUT);
        end
    end

    task automatic send_byte(input logic [7:0] b, output int c);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        c = cyc;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] cmd,
                             input int busy, input int extra, input int gap,
                             output int cmd_cyc, output int drop_cyc);
        int c;
        int res0;
        drop_cyc = -1;
        send_byte(a[7:0], c);  repeat (gap) @(negedge clk);
        send_byte(a[15:8], c); repeat (gap) @(negedge clk);
        send_byte(b[7:0], c);  repeat (gap) @(negedge clk);
        send_byte(b[15:8], c); repeat (gap) @(negedge clk);
        m_op1 = a;
        m_op2 = b;
        if (cmd <= 8'd3) begin
            m_ctrl      = cmd[1:0];
            bus.tx_busy = (busy > 0);
            if (busy == 0) exp_q.push_back(mk_ev(EV_RESULT));
            send_byte(cmd, cmd_cyc);
            check("alu_ctrl_latency", bus.alu_ctrl, m_ctrl);
            if (busy > 0) begin
                res0 = n_results;
                for (int i = 0; i < extra; i++) begin
                    exp_q.push_back(mk_ev(EV_OVERRUN));
                    send_byte(8'hAA, c);
                end
                repeat (busy) @(negedge clk);
                check("wait_tx_state_id", bus.state_id, 2'b11);
                check("wait_tx_no_result", n_results, res0);
                exp_q.push_back(mk_ev(EV_RESULT));
                bus.tx_busy = 1'b0;
                drop_cyc = cyc;
            end
        end else begin
            exp_q.push_back(mk_ev(EV_CMDERR));
            send_byte(cmd, cmd_cyc);
            check("cmd_err_state_id", bus.state_id, 2'b00);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op1"}, bus.op1, 16'h0);
        check({tag, "_op2"}, bus.op2, 16'h0);
        check({tag, "_alu_ctrl"}, bus.alu_ctrl, 2'd0);
        check({tag, "_state_id"}, bus.state_id, 2'b00);
        check({tag, "_result_valid"}, bus.result_valid, 1'b0);
        check({tag, "_cmd_err"}, bus.cmd_err, 1'b0);
        check({tag, "_overrun"}, bus.overrun, 1'b0);
        check({tag, "_timeout_err"}, bus.timeout_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cc, dc, c, r0, busy, extra;
        logic [15:0] a, b, o1, o2;
        logic [7:0]  cmd;

        bus.rx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        bus.tx_busy  = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic frame, transmitter idle: result two cycles after the command byte.
        r0 = n_results;
        run_frame(16'h1234, 16'h0005, 8'h00, 0, 0, 0, cc, dc);
        check("basic_result_latency", last_cyc[EV_RESULT] - cc, 2);
        check("basic_result_count", n_results - r0, 1);
        check("basic_op1", bus.op1, 16'h1234);
        check("basic_op2", bus.op2, 16'h0005);
        check("basic_alu_ctrl", bus.alu_ctrl, 2'd0);

        // Transmitter busy for 20 cycles: one result right after it frees up.
        r0 = n_results;
        run_frame(16'hBEEF, 16'h0102, 8'h01, 20, 0, 1, cc, dc);
        check("busy_result_after_release", last_cyc[EV_RESULT] - dc, 1);
        check("busy_result_count", n_results - r0, 1);

        // Illegal command: error pulse, opcode kept, no result.
        r0 = n_results;
        run_frame(16'h4321, 16'h8765, 8'h07, 0, 0, 0, cc, dc);
        check("cmd_err_latency", last_cyc[EV_CMDERR] - cc, 1);
        check("cmd_err_alu_ctrl_kept", bus.alu_ctrl, 2'd1);
        check("cmd_err_no_result", n_results - r0, 0);

        // Stray byte while waiting on the transmitter, then a clean frame.
        run_frame(16'h00FF, 16'hFF00, 8'h02, 6, 1, 0, cc, dc);
        run_frame(16'h5A5A, 16'hA5A5, 8'h03, 0, 0, 2, cc, dc);
        check("post_overrun_op1", bus.op1, 16'h5A5A);
        check("post_overrun_op2", bus.op2, 16'hA5A5);
        check("post_overrun_ctrl", bus.alu_ctrl, 2'd3);

        // Reset in the middle of a frame.
        send_byte(8'h11, c);
        send_byte(8'h22, c);
        send_byte(8'h33, c);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        reset  = 1'b0;
        m_op1  = 16'h0;
        m_op2  = 16'h0;
        m_ctrl = 2'd0;
        r0 = n_results;
        repeat (5) @(negedge clk);
        check("midreset_no_result", n_results - r0, 0);
        run_frame(16'hCAFE, 16'h0BAD, 8'h02, 0, 0, 0, cc, dc);
        check("midreset_frame_op1", bus.op1, 16'hCAFE);
        check("midreset_frame_op2", bus.op2, 16'h0BAD);
        check("midreset_frame_results", n_results - r0, 1);

`ifdef SEQ_TIMEOUT_EN
        // Stall after two bytes: the frame is abandoned after the timeout.
        send_byte(8'h11, c);
        send_byte(8'h22, c);
        m_op1 = 16'h2211;
        @(negedge clk);
        o1 = bus.op1;
        o2 = bus.op2;
        exp_q.push_back(mk_ev(EV_TIMEOUT));
        r0 = last_cyc[EV_TIMEOUT];
        for (int i = 0; i < 200 && last_cyc[EV_TIMEOUT] == r0; i++) @(negedge clk);
        check("timeout_latency_in_range",
              (last_cyc[EV_TIMEOUT] - c >= TB_TIMEOUT) && (last_cyc[EV_TIMEOUT] - c <= TB_TIMEOUT + 1), 1);
        check("timeout_state_id", bus.state_id, 2'b00);
        check("timeout_op1_kept", bus.op1, o1);
        check("timeout_op2_kept", bus.op2, o2);
        check("timeout_op1_word", bus.op1, 16'h2211);
        @(negedge clk);
`else
        // Without the timer a stalled frame simply waits for its next byte.
        send_byte(8'h11, c);
        send_byte(8'h22, c);
        repeat (150) @(negedge clk);
        check("no_timer_still_mid_frame", bus.state_id, 2'b10);
        check("no_timer_op1_word", bus.op1, 16'h2211);
        m_op1  = 16'h2211;
        m_op2  = 16'h4433;
        m_ctrl = 2'd1;
        send_byte(8'h33, c);
        send_byte(8'h44, c);
        exp_q.push_back(mk_ev(EV_RESULT));
        send_byte(8'h01, c);
        repeat (3) @(negedge clk);
`endif

        // Randomized frames, including illegal commands and busy waits with stray bytes.
        for (int n = 0; n < 40; n++) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            cmd   = 8'($urandom_range(0, 5));
            busy  = $urandom_range(0, 4);
            extra = (busy > 0) ? $urandom_range(0, 2) : 0;
            run_frame(a, b, cmd, busy, extra, $urandom_range(0, 2), cc, dc);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
